// File: rtl/accelerator_types.sv
// Shared types and constants for the matmul accelerator datapath blocks.
//   BYTE        : byte width in bits, used to derive strobe widths and
//                 per-beat address strides from a data width.
//   BURST_CNT_W : width of per-burst beat counters (holds 0..256).
//   wb_state_e  : write-back engine state encoding.
package accelerator_types;

  localparam int BYTE        = 8;
  localparam int BURST_CNT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_DONE = 3'd4
  } wb_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small synchronous FIFO that absorbs BRAM read latency and W-channel
// backpressure in the write-back engine.
//   clk_i, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write one entry (ignored when full)
//   pop, dout    : dout is the head entry; pop removes it (ignored when empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module wb_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/spad_writeback.sv
// Result write-back engine: drains the result scratchpad BRAM into DDR over
// the MIG AXI write channels (AW/W/B), splitting a transfer of len_i beats
// into bursts of at most MAX_BURST beats.
//
// Ports
//   clk_i, rst_n        : clock, asynchronous active-low reset
//   start_i             : one-cycle start pulse (ignored while busy_o)
//   dst_addr_i, len_i   : DDR byte base address and beat count, sampled on start
//   busy_o              : transfer in progress (through the done_o pulse)
//   done_o              : one-cycle completion pulse
//   bram_addr_o/en_o    : BRAM read port, data returns BRAM_LATENCY cycles later
//   bram_dout_i         : BRAM read data
//   addr_o, arwlen_o    : AW address and burst length minus one
//   awvalid_o/awready_i : AW handshake
//   wdata_o, wstrb_o    : W payload (strobes all-ones while wvalid_o)
//   wlast_o             : last beat of the burst
//   wvalid_o/wready_i   : W handshake
//   bvalid_i/bready_o   : B handshake (response code ignored)
//   state_o             : current FSM state, for observation only
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both high at the rising clock edge. A source never withdraws
// valid or changes its payload until that transfer happens, and never waits
// for ready before raising valid.
module spad_writeback
  import accelerator_types::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 1024,
  parameter int REG_WIDTH    = 32,
  parameter int MAX_BURST    = 256,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [ADDR_WIDTH-1:0]      dst_addr_i,
  input  logic [REG_WIDTH-1:0]       len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ADDR_WIDTH-1:0]      bram_addr_o,
  output logic                       bram_en_o,
  input  logic [DATA_WIDTH-1:0]      bram_dout_i,
  output logic [ADDR_WIDTH-1:0]      addr_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  output logic [7:0]                 arwlen_o,
  output logic [DATA_WIDTH-1:0]      wdata_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  output logic [DATA_WIDTH/BYTE-1:0] wstrb_o,
  output logic                       wlast_o,
  input  logic                       bvalid_i,
  output logic                       bready_o,
  output wb_state_e                  state_o
);

  // Latency + 2 entries keeps one beat per cycle flowing under steady wready.
  localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int STRB_W     = DATA_WIDTH / BYTE;

  wb_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [REG_WIDTH-1:0]    rem_q;
  logic [BURST_CNT_W-1:0]  rd_cnt_q;     // BRAM reads issued in this burst
  logic [BURST_CNT_W-1:0]  beat_q;       // W beats sent in this burst
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [CNT_W-1:0]        inflight_q;   // reads issued, data not yet pushed
  logic [BRAM_LATENCY-1:0] rd_pipe_q;    // marks cycles where read data lands
  logic                    done_q;

  logic [BURST_CNT_W-1:0]  burst;
  logic [BURST_CNT_W-1:0]  burst_m1;
  logic                    start_ok;
  logic                    rd_issue;
  logic                    w_hs;
  logic                    w_last_beat;

  logic                    fifo_push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_WIDTH-1:0]   fifo_dout;

  // Beats in the current burst; rem_q only moves on the B handshake, so this
  // is stable across the AW and W phases of a burst.
  always_comb begin
    burst = (rem_q >= REG_WIDTH'(MAX_BURST)) ? BURST_CNT_W'(MAX_BURST)
                                             : rem_q[BURST_CNT_W-1:0];
  end

  assign burst_m1    = burst - BURST_CNT_W'(1);
  assign w_last_beat = (beat_q == burst_m1);
  assign busy_o      = (state_q != S_IDLE) || done_q;
  // The done cycle counts as busy, so a start coinciding with done_o drops.
  assign start_ok    = start_i && !busy_o;
  assign w_hs        = wvalid_o && wready_i;
  assign fifo_push   = rd_pipe_q[BRAM_LATENCY-1];

  // Credit check: only read when every outstanding read already has a free
  // FIFO slot reserved, so returning data can never overflow the FIFO.
  // The full term is redundant with the credit check and kept as a guard.
  assign rd_issue = ((state_q == S_AW) || (state_q == S_W))
                 && (rd_cnt_q < burst)
                 && ((CNT_W'(FIFO_DEPTH) - fifo_count) > inflight_q)
                 && !fifo_full;

  wb_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (bram_dout_i),
    .pop   (w_hs),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state and channel outputs.
  always_comb begin
    state_d   = state_q;
    awvalid_o = 1'b0;
    addr_o    = '0;
    arwlen_o  = '0;
    wvalid_o  = 1'b0;
    wdata_o   = '0;
    wstrb_o   = '0;
    wlast_o   = 1'b0;
    bready_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (len_i != '0) ? S_AW : S_DONE;
        end
      end
      S_AW: begin
        awvalid_o = 1'b1;
        addr_o    = addr_q;
        arwlen_o  = burst_m1[7:0];
        if (awready_i) begin
          state_d = S_W;
        end
      end
      S_W: begin
        wvalid_o = !fifo_empty;
        if (wvalid_o) begin
          wdata_o = fifo_dout;
          wstrb_o = {STRB_W{1'b1}};
          wlast_o = w_last_beat;
        end
        if (w_hs && w_last_beat) begin
          state_d = S_B;
        end
      end
      S_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          state_d = (rem_q == REG_WIDTH'(burst)) ? S_DONE : S_AW;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      bram_addr_q <= '0;
      inflight_q  <= '0;
      rd_pipe_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == S_DONE);
      rd_pipe_q  <= (rd_pipe_q << 1) | BRAM_LATENCY'(rd_issue);
      inflight_q <= inflight_q + CNT_W'(rd_issue) - CNT_W'(fifo_push);

      if (state_q == S_IDLE && start_ok) begin
        addr_q      <= dst_addr_i;
        rem_q       <= len_i;
        bram_addr_q <= '0;
        rd_cnt_q    <= '0;
        beat_q      <= '0;
      end

      if (rd_issue) begin
        bram_addr_q <= bram_addr_q + ADDR_WIDTH'(1);
        rd_cnt_q    <= rd_cnt_q + BURST_CNT_W'(1);
      end

      if (w_hs) begin
        beat_q <= w_last_beat ? '0 : beat_q + BURST_CNT_W'(1);
      end

      if (state_q == S_B && bvalid_i) begin
        rem_q    <= rem_q - REG_WIDTH'(burst);
        addr_q   <= addr_q + ADDR_WIDTH'(burst) * ADDR_WIDTH'(STRB_W);
        rd_cnt_q <= '0;
      end
    end
  end

  assign done_o      = done_q;
  assign bram_en_o   = rd_issue;
  assign bram_addr_o = bram_addr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_spad_writeback.sv
// Bench for spad_writeback: directed transfers with a BRAM model, AXI
// write-channel responders, and a negedge monitor checking against queues.
module tb_spad_writeback;
  import accelerator_types::*;

  localparam int AW_W  = 32;
  localparam int DW    = 1024;
  localparam int RW    = 32;
  localparam int SW    = DW / BYTE;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            start_i = 1'b0;
  logic [AW_W-1:0] dst_addr_i = '0;
  logic [RW-1:0]   len_i = '0;
  logic            busy_o, done_o;
  logic [AW_W-1:0] bram_addr_o;
  logic            bram_en_o;
  logic [DW-1:0]   bram_dout_i;
  logic [AW_W-1:0] addr_o;
  logic            awvalid_o;
  logic            awready_i = 1'b1;
  logic [7:0]      arwlen_o;
  logic [DW-1:0]   wdata_o;
  logic            wvalid_o;
  logic            wready_i = 1'b1;
  logic [SW-1:0]   wstrb_o;
  logic            wlast_o;
  logic            bvalid_i = 1'b0;
  logic            bready_o;
  wb_state_e       state_o;

  spad_writeback u_dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .dst_addr_i  (dst_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bram_addr_o (bram_addr_o),
    .bram_en_o   (bram_en_o),
    .bram_dout_i (bram_dout_i),
    .addr_o      (addr_o),
    .awvalid_o   (awvalid_o),
    .awready_i   (awready_i),
    .arwlen_o    (arwlen_o),
    .wdata_o     (wdata_o),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready_i),
    .wstrb_o     (wstrb_o),
    .wlast_o     (wlast_o),
    .bvalid_i    (bvalid_i),
    .bready_o    (bready_o),
    .state_o     (state_o)
  );

  // ---------------- BRAM model (latency 2) ----------------
  function automatic logic [DW-1:0] word_of(input logic [AW_W-1:0] idx);
    return {(DW/32){32'hC0DE_0000 ^ idx}};
  endfunction

  logic [DW-1:0] bram_r1 = '0;
  logic [DW-1:0] bram_r2 = '0;
  always @(posedge clk_i) begin
    bram_r1 <= bram_en_o ? word_of(bram_addr_o) : '0;
    bram_r2 <= bram_r1;
  end
  assign bram_dout_i = bram_r2;

  // ---------------- scoreboard state ----------------
  logic [39:0] aw_exp_q[$];   // {addr, arwlen}
  logic [32:0] exp_q[$];      // {wlast, bram word index}
  int checks = 0;
  int errors = 0;
  int b_owed = 0;
  int done_cnt = 0;
  int aw_cnt = 0;
  int aw_stall_cnt = 0;
  int w_beats = 0;
  int next_rd = 0;
  int aw_stall_cfg = 0;
  bit wr_random = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ok(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: AXI responders ----------------
  initial begin
    int aw_wait;
    aw_wait = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (awvalid_o && aw_wait < aw_stall_cfg) begin
        awready_i = 1'b0;
        aw_wait++;
      end else begin
        awready_i = 1'b1;
        if (!awvalid_o) aw_wait = 0;
      end
      wready_i = wr_random ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid_i = rst_n && (b_owed > 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit            aw_seen, aw_stall_prev, w_stall_prev, prev_wlast;
    logic [AW_W-1:0] prev_addr;
    logic [7:0]    prev_len;
    logic [DW-1:0] prev_wdata, exp_word;
    logic [39:0]   ea;
    logic [32:0]   ew;
    logic [31:0]   lo_exp;
    aw_seen = 0; aw_stall_prev = 0; w_stall_prev = 0; prev_wlast = 0;
    prev_addr = '0; prev_len = '0; prev_wdata = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        aw_exp_q.delete();
        exp_q.delete();
        b_owed = 0; aw_seen = 0; aw_stall_prev = 0; w_stall_prev = 0;
        next_rd = 0;
      end else begin
        if (start_i && !busy_o) begin
          next_rd = 0;
          w_beats = 0;
        end
        if (bram_en_o) begin
          chk("bram_addr", bram_addr_o, next_rd);
          next_rd++;
        end
        // AW channel
        if (aw_stall_prev) begin
          chk("aw_hold_valid", awvalid_o, 1);
          chk("aw_hold_addr", addr_o, prev_addr);
          chk("aw_hold_len", arwlen_o, prev_len);
        end
        if (awvalid_o && !awready_i) aw_stall_cnt++;
        if (awvalid_o && awready_i) begin
          aw_cnt++;
          aw_seen = 1;
          if (aw_exp_q.size() == 0) begin
            chk_ok(0, "aw_unexpected", addr_o, 0);
          end else begin
            ea = aw_exp_q.pop_front();
            chk("aw_addr", addr_o, ea[39:8]);
            chk("aw_len", arwlen_o, ea[7:0]);
          end
        end
        aw_stall_prev = awvalid_o && !awready_i;
        prev_addr = addr_o;
        prev_len = arwlen_o;
        // W channel
        if (w_stall_prev) begin
          chk("w_hold_valid", wvalid_o, 1);
          chk_ok(wdata_o == prev_wdata, "w_hold_data", wdata_o[31:0], prev_wdata[31:0]);
          chk("w_hold_last", wlast_o, prev_wlast);
        end
        if (wvalid_o) begin
          chk_ok(wstrb_o == {SW{1'b1}}, "wstrb_ones", wstrb_o[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
          chk("w_after_aw", aw_seen, 1);
        end
        if (wvalid_o && wready_i) begin
          w_beats++;
          if (exp_q.size() == 0) begin
            chk_ok(0, "w_unexpected", wdata_o[31:0], 0);
          end else begin
            ew = exp_q.pop_front();
            exp_word = word_of(ew[31:0]);
            lo_exp = exp_word[31:0];
            chk_ok(wdata_o == exp_word, "w_data", wdata_o[31:0], lo_exp);
            chk("w_last", wlast_o, ew[32]);
          end
          if (wlast_o) begin
            aw_seen = 0;
            b_owed++;
          end
        end
        w_stall_prev = wvalid_o && !wready_i;
        prev_wdata = wdata_o;
        prev_wlast = wlast_o;
        // B channel and completion
        if (bvalid_i && bready_o) b_owed--;
        if (done_o) done_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_burst(input logic [AW_W-1:0] addr, input int beats, input int first_idx);
    aw_exp_q.push_back({addr, 8'(beats - 1)});
    for (int i = 0; i < beats; i++) begin
      exp_q.push_back({(i == beats - 1), 32'(first_idx + i)});
    end
  endtask

  task automatic start_xfer(input logic [AW_W-1:0] addr, input int len);
    @(posedge clk_i); #1;
    dst_addr_i = addr;
    len_i = RW'(len);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("aw_rise", awvalid_o, 1);
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(input string tag, input int base, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      @(posedge clk_i);
      if (done_cnt > base) break;
    end
    if (i == max_cycles) chk_ok(0, {tag, "_done_timeout"}, done_cnt, base + 1);
    repeat (4) @(posedge clk_i);
    chk({tag, "_done_once"}, done_cnt - base, 1);
  endtask

  task automatic check_drained(input string tag);
    #1;
    chk({tag, "_aw_q_empty"}, aw_exp_q.size(), 0);
    chk({tag, "_w_q_empty"}, exp_q.size(), 0);
    chk({tag, "_b_owed"}, b_owed, 0);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_bram_en"}, bram_en_o, 0);
    chk({tag, "_bram_addr"}, bram_addr_o, 0);
    chk({tag, "_awvalid"}, awvalid_o, 0);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_arwlen"}, arwlen_o, 0);
    chk({tag, "_wvalid"}, wvalid_o, 0);
    chk_ok(wdata_o == '0, {tag, "_wdata"}, wdata_o[31:0], 0);
    chk_ok(wstrb_o == '0, {tag, "_wstrb"}, wstrb_o[63:0], 0);
    chk({tag, "_wlast"}, wlast_o, 0);
    chk({tag, "_bready"}, bready_o, 0);
    chk({tag, "_state"}, state_o, S_IDLE);
    chk({tag, "_fifo_count"}, u_dut.u_fifo.count, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base, aw_base, st_base;

    // reset state
    repeat (3) @(posedge clk_i);
    #2;
    check_outputs_zero("rst");
    @(posedge clk_i); #1;
    rst_n = 1'b1;

    // single burst: 4 beats at 0x1000
    base = done_cnt;
    push_burst(32'h0000_1000, 4, 0);
    start_xfer(32'h0000_1000, 4);
    wait_done("single", base, 200);
    check_drained("single");

    // burst split: 300 beats -> 256 + 44, stride 256*128 bytes
    base = done_cnt;
    push_burst(32'h0000_0000, 256, 0);
    push_burst(32'h0000_8000, 44, 256);
    start_xfer(32'h0000_0000, 300);
    wait_done("split", base, 2000);
    check_drained("split");
    chk("split_reads", next_rd, 300);

    // random W backpressure
    base = done_cnt;
    wr_random = 1'b1;
    push_burst(32'h2000_0000, 16, 0);
    start_xfer(32'h2000_0000, 16);
    wait_done("bp", base, 500);
    wr_random = 1'b0;
    check_drained("bp");

    // AW stall of 5 cycles
    base = done_cnt;
    st_base = aw_stall_cnt;
    aw_stall_cfg = 5;
    push_burst(32'h0000_0040, 8, 0);
    start_xfer(32'h0000_0040, 8);
    wait_done("awstall", base, 500);
    aw_stall_cfg = 0;
    chk("awstall_cycles", aw_stall_cnt - st_base, 5);
    check_drained("awstall");

    // zero length, then a start coinciding with done_o
    base = done_cnt;
    aw_base = aw_cnt;
    @(posedge clk_i); #1;
    dst_addr_i = 32'h0000_5000;
    len_i = '0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("zl_done_cycle1", done_o, 0);
    chk("zl_busy_cycle1", busy_o, 1);
    @(posedge clk_i); #1;
    len_i = 32'd4;
    start_i = 1'b1;
    @(negedge clk_i);
    chk("zl_done_cycle2", done_o, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    len_i = '0;
    @(negedge clk_i);
    chk("zl_done_cycle3", done_o, 0);
    repeat (10) @(posedge clk_i);
    #1;
    chk("zl_no_aw", aw_cnt - aw_base, 0);
    chk("zl_done_once", done_cnt - base, 1);
    chk("zl_idle", busy_o, 0);

    // start while busy is ignored
    base = done_cnt;
    aw_base = aw_cnt;
    push_burst(32'h0000_3000, 16, 0);
    start_xfer(32'h0000_3000, 16);
    repeat (3) @(posedge clk_i);
    #1;
    dst_addr_i = 32'h0000_9000;
    len_i = 32'd5;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("busy", base, 500);
    chk("busy_one_aw", aw_cnt - aw_base, 1);
    check_drained("busy");

    // reset at beat 7 of 16, then a fresh 2-beat transfer
    push_burst(32'h0000_7000, 16, 0);
    start_xfer(32'h0000_7000, 16);
    begin
      int i;
      for (i = 0; i < 300; i++) begin
        @(posedge clk_i);
        if (w_beats >= 7) break;
      end
      if (i == 300) chk_ok(0, "rst_mid_beat7_timeout", w_beats, 7);
    end
    chk("rst_mid_beats_before", w_beats, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    @(negedge clk_i);
    @(posedge clk_i); #3;
    rst_n = 1'b1;
    base = done_cnt;
    push_burst(32'h0000_A000, 2, 0);
    start_xfer(32'h0000_A000, 2);
    wait_done("after_rst", base, 200);
    check_drained("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spad_writeback.md
# spad_writeback

Result write-back engine for the matmul accelerator. It drains a result scratchpad BRAM into DDR through the MIG AXI write channels (AW/W/B). It splits an arbitrary-length transfer into bursts and absorbs BRAM read latency and `wready` backpressure with a small skid FIFO. It is the outbound counterpart of the scratchpad fill path and sits between the result BRAM read port and the MIG write port during the accelerator's write-back phase.

## Interface
- `ADDR_WIDTH`, 32: DDR byte address and BRAM word address width.
- `DATA_WIDTH`, 1024: beat width; one BRAM word per beat.
- `REG_WIDTH`, 32: length register width.
- `MAX_BURST`, 256: maximum beats per AXI burst (1..256).
- `BRAM_LATENCY`, 2: BRAM read latency in cycles (≥1).

- `clk_i` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle start pulse.
- `dst_addr_i` in ADDR_WIDTH: DDR byte base address; sampled on an accepted start.
- `len_i` in REG_WIDTH: total beats; sampled on an accepted start.
- `busy_o` out 1: high from the accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse after the final B response.
- `bram_addr_o` out ADDR_WIDTH: result BRAM word read address.
- `bram_en_o` out 1: BRAM read enable.
- `bram_dout_i` in DATA_WIDTH: BRAM read data, valid BRAM_LATENCY cycles after `bram_en_o`.
- `addr_o` out ADDR_WIDTH: AW address.
- `awvalid_o` out 1: AW valid.
- `awready_i` in 1: AW ready.
- `arwlen_o` out 8: burst length minus 1.
- `wdata_o` out DATA_WIDTH: W data.
- `wvalid_o` out 1: W valid.
- `wready_i` in 1: W ready.
- `wstrb_o` out DATA_WIDTH/8: W byte strobes.
- `wlast_o` out 1: last beat of the current burst.
- `bvalid_i` in 1: B valid.
- `bready_o` out 1: B ready.

## Operation
- States: `S_IDLE`, `S_AW`, `S_W`, `S_B`, `S_DONE`.
- `S_IDLE`, start with `len_i`≠0:
  - Latch base address and remaining = `len_i`.
  - Clear the BRAM read pointer.
  - Go to `S_AW`.
- `S_IDLE`, start with `len_i`=0: go directly to `S_DONE`; no bus traffic.
- `start_i` while `busy_o` is high is ignored.
- `S_AW`:
  - Burst length is `min(remaining, MAX_BURST)`.
  - Drive `awvalid_o`=1 with `addr_o` and `arwlen_o` = burst−1; hold all three stable until `awready_i`.
  - On the AW handshake, go to `S_W`.
- BRAM prefetch is allowed from `S_AW` onward:
  - Issue a read whenever FIFO free slots exceed in-flight reads and beats read < beats in the current burst.
  - `bram_addr_o` increments by 1 per read and is continuous across bursts.
- `S_W`:
  - `wvalid_o` = FIFO not empty; `wdata_o` = FIFO head.
  - A beat transfers when `wvalid_o && wready_i`, which pops the FIFO.
  - `wlast_o` is high on the beat where the burst beat counter equals burst−1.
  - After the wlast handshake, go to `S_B`.
- `S_B`:
  - `bready_o`=1.
  - On `bvalid_i`: remaining −= burst; address += burst × DATA_WIDTH/8.
  - Go to `S_AW` if remaining≠0, else `S_DONE`.
  - The response code is ignored.
- `S_DONE`: `done_o`=1 for one cycle, then `S_IDLE`.
- `wstrb_o` is all-ones whenever `wvalid_o` is high, and 0 otherwise.
- Width rules:
  - The remaining count is REG_WIDTH wide.
  - The burst counter is 9 bits.
  - The address adder wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: every output is 0; the FIFO is empty; state is `S_IDLE`.
- `awvalid_o` rises the cycle after an accepted start.
- `wvalid_o` never precedes the AW handshake of its burst.
- With zero stalls, the first W beat is no later than max(AW handshake + 1, first BRAM read + BRAM_LATENCY + 1).
- Under continuous `wready_i`, W sustains 1 beat/cycle: FIFO depth = BRAM_LATENCY + 2.
- `wready_i` dropping never loses or duplicates data; outputs hold stable while stalled.
- Zero-length start: `done_o` pulses 2 cycles after the start.
- `bvalid_i` arriving in the same cycle `bready_o` rises is accepted.
- A start in the same cycle as `done_o` is ignored.
- Asynchronous reset mid-burst:
  - Abandons the transfer immediately; all outputs return to their reset values.
  - The MIG side must be reset by the system alongside.

## Structure
- `wb_state_e` belongs in `accelerator_types`.
- The `BYTE` constant (byte width in bits, used for DATA_WIDTH/8) belongs in `accelerator_types`.
- One sub-module: `wb_skid_fifo`, a synchronous FIFO parameterised by width and depth with push/pop/full/empty/count. The read-issue credit logic uses its count.

## Test plan
- Single burst: `len_i`=4, `dst_addr_i`=0x1000 -> one AW with `arwlen_o`=3, 4 W beats carrying BRAM words 0..3, `wlast_o` on beat 4, then `done_o`.
- Burst split: `len_i`=300, `MAX_BURST`=256, `DATA_WIDTH`=1024 -> two bursts:
  - AW 0x0 with len 255.
  - AW 0x8000 with len 43.
  - BRAM addresses 0..299 read exactly once each.
- Backpressure: `wready_i` toggles 1-0-0-1 randomly during `len_i`=16 -> all 16 words arrive in order with no drops or duplicates; outputs are stable while stalled.
- AW stall: `awready_i` held low 5 cycles -> `awvalid_o`, `addr_o`, `arwlen_o` held stable; no `wvalid_o` before the handshake.
- Zero length, and start while busy: `len_i`=0 -> `done_o` pulses with no AW; a second start during a 16-beat transfer is ignored.
- Reset mid-burst: `rst_n` asserted low at beat 7 of 16 -> all outputs are 0 immediately and the FIFO is empty; a fresh start of `len_i`=2 then completes normally.
